rom_fetch_unit: RTL and testbench

Sequential instruction-fetch initiator for the byte-wide, combinationally-read instruction ROM. On a start request it reads four consecutive bytes from the ROM and assembles one 32-bit little-endian instruction word. It flags misaligned program counters and ROM-reported illegal addresses. It sits between the CPU control FSM (pc/start/done) and the ROM's address/read_data/illegal_address port.

---
 rtl/rom_fetch_unit.sv | 120 ++++++++++++
 tb/tb_rom_fetch_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_unit.sv
// rom_fetch_unit
// Fetches one 32-bit little-endian instruction from a byte-wide ROM whose read
// port is combinational. One byte is read per cycle starting at the captured pc,
// and bytes are placed from the low lane upwards. A misaligned pc can be rejected
// before any ROM access. A ROM out-of-range flag aborts the fetch and reports the
// offending byte address.
module rom_fetch_unit (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        check_alignment,
    input  logic [31:0] pc,
    output logic        busy,
    output logic        done,
    output logic [31:0] instruction,
    output logic        error,
    output logic [1:0]  error_cause,
    output logic [31:0] fault_address,
    output logic [31:0] rom_address,
    input  logic [7:0]  rom_read_data,
    input  logic        rom_illegal_address
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_NONE       = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGNED = 2'd1;
    localparam logic [1:0] CAUSE_ILLEGAL    = 2'd2;

    state_t      state_reg;
    logic [1:0]  count_reg;
    logic [31:0] pc_reg;

    // The next ROM address is rebuilt from the captured pc, so the 32-bit add
    // wraps naturally past 0xFFFFFFFF back to 0.
    logic [31:0] next_address;
    assign next_address = pc_reg + 32'(count_reg) + 32'd1;

    // Fetch sequencer: every output is registered here. rom_address is held as a
    // register so that it keeps its last driven value while idle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            count_reg     <= 2'd0;
            pc_reg        <= 32'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            instruction   <= 32'd0;
            error         <= 1'b0;
            error_cause   <= CAUSE_NONE;
            fault_address <= 32'd0;
            rom_address   <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        pc_reg        <= pc;
                        count_reg     <= 2'd0;
                        busy          <= 1'b1;
                        instruction   <= 32'd0;
                        error         <= 1'b0;
                        error_cause   <= CAUSE_NONE;
                        fault_address <= 32'd0;
                        if (check_alignment && (pc[1:0] != 2'b00)) begin
                            // Rejected before touching the ROM.
                            error         <= 1'b1;
                            error_cause   <= CAUSE_MISALIGNED;
                            fault_address <= pc;
                            done          <= 1'b1;
                            state_reg     <= DONE;
                        end else begin
                            rom_address <= pc;
                            state_reg   <= READ;
                        end
                    end
                end

                READ: begin
                    if (rom_illegal_address) begin
                        // Abort: partially collected bytes are thrown away.
                        error         <= 1'b1;
                        error_cause   <= CAUSE_ILLEGAL;
                        fault_address <= rom_address;
                        instruction   <= 32'd0;
                        done          <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        instruction[8*count_reg +: 8] <= rom_read_data;
                        if (count_reg == 2'd3) begin
                            done      <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            count_reg   <= count_reg + 2'd1;
                            rom_address <= next_address;
                        end
                    end
                end

                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_fetch_unit.sv
// tb_rom_fetch_unit
// Directed and randomized fetches against a byte-array ROM model. Expected
// results come from walking the four byte addresses of each request directly.
module tb_rom_fetch_unit;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        check_alignment;
    logic [31:0] pc;
    logic        busy;
    logic        done;
    logic [31:0] instruction;
    logic        error;
    logic [1:0]  error_cause;
    logic [31:0] fault_address;
    logic [31:0] rom_address;
    logic [7:0]  rom_read_data;
    logic        rom_illegal_address;

    int vectors;
    int miscompares;
    logic [31:0] last_addr;

    // ROM: legal at 0x000..0x7FF plus a high window 0xFFFFFFF0..0xFFFFFFFF
    // (aliased onto the top of the array) so address wrap can be exercised.
    logic [7:0] mem [0:2047];

    assign rom_illegal_address = !((rom_address < 32'h800) || (rom_address >= 32'hFFFF_FFF0));
    assign rom_read_data       = rom_illegal_address ? 8'hEE : mem[rom_address[10:0]];

    rom_fetch_unit dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .start               (start),
        .check_alignment     (check_alignment),
        .pc                  (pc),
        .busy                (busy),
        .done                (done),
        .instruction         (instruction),
        .error               (error),
        .error_cause         (error_cause),
        .fault_address       (fault_address),
        .rom_address         (rom_address),
        .rom_read_data       (rom_read_data),
        .rom_illegal_address (rom_illegal_address)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic rom_legal(input logic [31:0] a);
        return (a < 32'h800) || (a >= 32'hFFFF_FFF0);
    endfunction

    function automatic logic [7:0] rom_byte(input logic [31:0] a);
        return mem[a[10:0]];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request: model computes latency, addresses and result, then the DUT
    // is followed cycle by cycle. Spurious start pulses are thrown in while busy.
    task automatic do_fetch(input logic [31:0] p, input logic ca);
        logic [31:0] exp_instr;
        logic [31:0] exp_fault;
        logic [31:0] a;
        logic        exp_err;
        logic [1:0]  exp_cause;
        logic        stop;
        int          lat;
        int          n_reads;

        exp_instr = 32'd0;
        exp_fault = 32'd0;
        exp_err   = 1'b0;
        exp_cause = 2'd0;
        stop      = 1'b0;
        lat       = 5;
        n_reads   = 0;
        if (ca && (p[1:0] != 2'b00)) begin
            exp_err   = 1'b1;
            exp_cause = 2'd1;
            exp_fault = p;
            lat       = 1;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (!stop) begin
                    a       = p + 32'(k);
                    n_reads = k + 1;
                    if (!rom_legal(a)) begin
                        exp_err   = 1'b1;
                        exp_cause = 2'd2;
                        exp_fault = a;
                        exp_instr = 32'd0;
                        lat       = 2 + k;
                        stop      = 1'b1;
                    end else begin
                        exp_instr[8*k +: 8] = rom_byte(a);
                    end
                end
            end
        end

        pc              = p;
        check_alignment = ca;
        start           = 1'b1;
        @(posedge clock);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clock);
            start = (c < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
            pc    = $urandom;
            check("busy", 32'(busy), 32'd1);
            check("done", 32'(done), 32'(c == lat));
            if (c <= n_reads)
                check("rom_address", rom_address, p + 32'(c - 1));
            if (c == lat) begin
                check("instruction", instruction, exp_instr);
                check("error", 32'(error), 32'(exp_err));
                check("error_cause", 32'(error_cause), 32'(exp_cause));
                check("fault_address", fault_address, exp_fault);
            end
        end
        // First idle cycle: strobes low, results held, rom_address held.
        @(negedge clock);
        if (n_reads > 0)
            last_addr = p + 32'(n_reads - 1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("hold_instruction", instruction, exp_instr);
        check("hold_error", 32'(error), 32'(exp_err));
        check("hold_fault", fault_address, exp_fault);
        check("hold_rom_address", rom_address, last_addr);
        $display("fetch pc=%h ca=%0d latency=%0d instr=%h err=%0d cause=%0d fault=%h",
                 p, ca, lat, instruction, error, error_cause, fault_address);
    endtask

    initial begin
        logic [31:0] p;
        int          m;
        logic [31:0] held_instr;

        vectors         = 0;
        miscompares     = 0;
        last_addr       = 32'd0;
        start           = 1'b0;
        check_alignment = 1'b0;
        pc              = 32'd0;
        for (int i = 0; i < 2048; i++)
            mem[i] = 8'($urandom);

        // Reset state
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_instruction", instruction, 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_cause", 32'(error_cause), 32'd0);
        check("rst_fault", fault_address, 32'd0);
        check("rst_rom_address", rom_address, 32'd0);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Directed fetches from the plan
        mem[32'h100] = 8'h10; mem[32'h101] = 8'h20;
        mem[32'h102] = 8'h30; mem[32'h103] = 8'h40;
        do_fetch(32'h100, 1'b1);
        check("plan_word_0x100", instruction, 32'h4030_2010);
        do_fetch(32'h102, 1'b1);
        mem[32'h102] = 8'hAA; mem[32'h103] = 8'hBB;
        mem[32'h104] = 8'hCC; mem[32'h105] = 8'hDD;
        do_fetch(32'h102, 1'b0);
        check("plan_word_0x102", instruction, 32'hDDCC_BBAA);
        do_fetch(32'h7FE, 1'b0);
        do_fetch(32'h7FC, 1'b1);
        do_fetch(32'h800, 1'b0);
        do_fetch(32'hFFFF_FFFE, 1'b0);
        do_fetch(32'hFFFF_FFFC, 1'b1);

        // start held high: one accept every 6 cycles
        held_instr = {mem[32'h103], mem[32'h102], mem[32'h101], mem[32'h100]};
        pc              = 32'h100;
        check_alignment = 1'b0;
        start           = 1'b1;
        @(posedge clock);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clock);
            m = c % 6;
            if (c == 18)
                start = 1'b0;
            check("held_busy", 32'(busy), 32'(m != 0));
            check("held_done", 32'(done), 32'(m == 5));
            if (m >= 1 && m <= 4)
                check("held_rom_address", rom_address, 32'h100 + 32'(m - 1));
            if (m == 5)
                check("held_instruction", instruction, held_instr);
        end
        last_addr = 32'h103;
        $display("held start: 3 fetches from pc=00000100 instr=%h", instruction);

        // Reset in the middle of a fetch (cycle T+3)
        pc              = 32'h104;
        check_alignment = 1'b1;
        start           = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_instruction", instruction, 32'd0);
        check("mid_rst_error", 32'(error), 32'd0);
        check("mid_rst_fault", fault_address, 32'd0);
        check("mid_rst_rom_address", rom_address, 32'd0);
        @(negedge clock);
        reset_n   = 1'b1;
        last_addr = 32'd0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            check("post_rst_done", 32'(done), 32'd0);
            check("post_rst_busy", 32'(busy), 32'd0);
        end
        $display("reset mid-fetch: outputs cleared, no done pulse");
        do_fetch(32'h104, 1'b1);

        // Randomized fetches around the interesting regions
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       p = 32'($urandom_range(0, 32'h7FF));
                1:       p = 32'h7F8 + 32'($urandom_range(0, 15));
                2:       p = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: p = $urandom;
            endcase
            do_fetch(p, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
